serial_addsub: RTL and testbench

//   Bit-serial two's-complement adder/subtractor: one result bit per clock through a single full adder.
//   The area-cheap sequential counterpart of the parallel ripple-carry arithmetic in this library.

---
 rtl/serial_addsub_pkg.sv | 10 +
 rtl/rca_fa.sv | 11 +
 rtl/serial_addsub.sv | 95 +++++++++
 tb/tb_serial_addsub.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and opcode constants
package serial_addsub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/rca_fa.sv
// rca_fa: 1-bit full adder
module rca_fa (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one bit per clock
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic             fa_s, fa_c;
  rca_fa u_fa (
    .sum  (fa_s),
    .c_out(fa_c),
    .a    (a_q[count_q]),
    .b    (b_q[count_q]),
    .c_in (carry_q)
  );
  // next-state: latch operands on start, then shift one full-adder bit per cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        count_d = '0;
        a_d     = a;
        b_d     = (op == OP_SUB) ? ~b : b;
        carry_d = (op == OP_SUB);
        sum_d   = '0;
        c_out_d = 1'b0;
        ovf_d   = 1'b0;
      end
      ST_RUN: begin
        sum_d[count_q] = fa_s;
        carry_d        = fa_c;
        if (count_q == CW'(WIDTH - 1)) begin
          c_out_d = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized and directed check of serial_addsub against an arithmetic model
module tb_serial_addsub;
  localparam int W = 4;
  localparam int M = 1 << W;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;
  int tests = 0, fails = 0;
  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic o, input int x, input int y,
                                output int es, output int ec, output int ev);
    int sx, sy, r, u;
    sx = (x >= M / 2) ? x - M : x;
    sy = (y >= M / 2) ? y - M : y;
    r  = o ? sx - sy : sx + sy;
    u  = o ? x + M - y : x + y;
    es = u % M;
    ec = (u >= M) ? 1 : 0;
    ev = (r > M / 2 - 1 || r < -(M / 2)) ? 1 : 0;
  endfunction
  task automatic run_op(input logic o, input int x, input int y, input bit inject);
    int es, ec, ev;
    model(o, x, y, es, ec, ev);
    start = 1'b1; op = o; a = W'(x); b = W'(y);
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = W'($urandom); b = W'($urandom);
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("sum_cleared", sum, 0);
    for (int i = 1; i <= W; i++) begin
      if (inject && i == 2) begin
        start = 1'b1; op = $urandom; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < W) begin
        chk("busy_run", busy, 1);
        chk("done_early", done, 0);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("sum", sum, es);
        chk("c_out", c_out, ec);
        chk("overflow", overflow, ev);
      end
    end
    @(posedge clk); #1;
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_held", sum, es);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 5, 3, 1'b0);
    chk("t1_sum_lit", sum, 8); chk("t1_ovf_lit", overflow, 1);
    run_op(1'b1, 7, 2, 1'b0);
    chk("t2_sum_lit", sum, 5); chk("t2_cout_lit", c_out, 1);
    run_op(1'b1, 2, 7, 1'b0);
    chk("t3_sum_lit", sum, 11); chk("t3_cout_lit", c_out, 0);
    run_op(1'b0, 15, 1, 1'b0);
    chk("t4a_sum_lit", sum, 0); chk("t4a_cout_lit", c_out, 1);
    run_op(1'b1, 8, 1, 1'b0);
    chk("t4b_sum_lit", sum, 7); chk("t4b_ovf_lit", overflow, 1);
    run_op(1'b0, 3, 4, 1'b1);
    chk("t5_sum_lit", sum, 7);
    start = 1'b1; op = 1'b0; a = 4'd9; b = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    run_op(1'b0, 6, 6, 1'b0);
    chk("t6_sum_lit", sum, 12); chk("t6_cout_lit", c_out, 0); chk("t6_ovf_lit", overflow, 1);
    for (int n = 0; n < 20; n++)
      run_op(1'($urandom), int'($urandom_range(M - 1)), int'($urandom_range(M - 1)), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
